// File: rtl/pitch_frame_smoother.sv
// pitch_frame_smoother: clamps raw pitch estimates, low-pass filters them once
// per video frame and holds the result steady for the whole frame. Raises
// lost_out after TIMEOUT_FRAMES frames in a row with no estimate, then decays
// the output toward MIN_FREQ until pitch comes back.
// Optional build macro: MEDIAN3_EN. When defined, the filter input is the
// median of the last three per-frame samples, which rejects single-frame spikes.
module pitch_frame_smoother #(
   parameter logic [15:0] MIN_FREQ       = 16'd0,
   parameter logic [15:0] MAX_FREQ       = 16'd2044,
   parameter int          ALPHA_SHIFT    = 2,
   parameter int          TIMEOUT_FRAMES = 30
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [15:0] freq_in,
   input  logic        freq_valid_in,
   input  logic        new_frame_in,
   output logic [15:0] freq_out,
   output logic        lost_out
);

   localparam int            CW  = (TIMEOUT_FRAMES < 2) ? 1 : $clog2(TIMEOUT_FRAMES + 1);
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT_FRAMES);

   typedef enum logic [1:0] {IDLE, TRACK, LOST} state_t;

   state_t        state, state_nxt;
   logic [15:0]   pend, pend_nxt;
   logic          pend_vld, pend_vld_nxt;
   logic [15:0]   freq_nxt;
   logic          lost_nxt;
   logic [CW-1:0] miss, miss_nxt;
   logic [15:0]   clamped, sample, target;
   logic          have;

   // One filter step: cur + ((tgt - cur) >>> ALPHA_SHIFT). The 17-bit difference
   // keeps the sign; because tgt is always within the clamp range the true
   // result fits in 16 bits, so a modular 16-bit add is exact.
   function automatic logic [15:0] step_toward(input logic [15:0] cur, input logic [15:0] tgt);
      logic signed [16:0] diff;
      diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
      diff = diff >>> ALPHA_SHIFT;
      return cur + diff[15:0];
   endfunction

   // Clamp the incoming estimate into [MIN_FREQ, MAX_FREQ]
   always_comb begin
      clamped = freq_in;
      if (freq_in <= MIN_FREQ)      clamped = MIN_FREQ;
      else if (freq_in >= MAX_FREQ) clamped = MAX_FREQ;
   end

   // A strobe coinciding with the frame pulse bypasses the pending register
   assign sample = freq_valid_in ? clamped : pend;
   assign have   = freq_valid_in | pend_vld;

`ifdef MEDIAN3_EN
   // Only the two previous accepted samples are stored; the current sample
   // completes the three-entry window, so the oldest entry is never needed.
   logic [1:0][15:0] hist, hist_nxt;

   function automatic logic [15:0] med3(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c);
      logic [15:0] lo, hi;
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      hi = (hi < c) ? hi : c;
      return (lo > hi) ? lo : hi;
   endfunction

   assign target = med3(sample, hist[0], hist[1]);

   // History shifts on filtered updates and is flooded on direct loads
   always_comb begin
      hist_nxt = hist;
      if (new_frame_in && have) begin
         if (state == TRACK) hist_nxt = {hist[0], sample};
         else                hist_nxt = {sample, sample};
      end
   end

   // History register
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) hist <= '0;
      else         hist <= hist_nxt;
   end
`else
   assign target = sample;
`endif

   // Next-state and output logic; everything only moves on the frame pulse
   // except capture of the pending sample
   always_comb begin
      state_nxt    = state;
      freq_nxt     = freq_out;
      lost_nxt     = lost_out;
      miss_nxt     = miss;
      pend_nxt     = pend;
      pend_vld_nxt = pend_vld;
      if (freq_valid_in) begin
         pend_nxt     = clamped;
         pend_vld_nxt = 1'b1;
      end
      if (new_frame_in) begin
         pend_vld_nxt = 1'b0;
         case (state)
            IDLE: begin
               if (have) begin
                  freq_nxt  = sample;
                  miss_nxt  = '0;
                  state_nxt = TRACK;
               end
            end
            TRACK: begin
               if (have) begin
                  freq_nxt = step_toward(freq_out, target);
                  miss_nxt = '0;
               end else if (miss >= TMO - 1'b1) begin
                  miss_nxt  = TMO;
                  lost_nxt  = 1'b1;
                  state_nxt = LOST;
               end else begin
                  miss_nxt = miss + 1'b1;
               end
            end
            LOST: begin
               if (have) begin
                  freq_nxt  = sample;
                  lost_nxt  = 1'b0;
                  miss_nxt  = '0;
                  state_nxt = TRACK;
               end else begin
                  freq_nxt = step_toward(freq_out, MIN_FREQ);
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State, output and pending registers
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state    <= IDLE;
         freq_out <= MIN_FREQ;
         lost_out <= 1'b0;
         miss     <= '0;
         pend     <= '0;
         pend_vld <= 1'b0;
      end else begin
         state    <= state_nxt;
         freq_out <= freq_nxt;
         lost_out <= lost_nxt;
         miss     <= miss_nxt;
         pend     <= pend_nxt;
         pend_vld <= pend_vld_nxt;
      end
   end

endmodule

// File: tb/tb_pitch_frame_smoother.sv
// Testbench for pitch_frame_smoother: directed scenarios followed by random
// traffic, all checked every cycle against a frame-level reference model.
module tb_pitch_frame_smoother;

   localparam int MINF = 0;
   localparam int MAXF = 2044;
   localparam int A    = 2;
   localparam int T    = 3;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [15:0] freq_in;
   logic        freq_valid_in;
   logic        new_frame_in;
   logic [15:0] freq_out;
   logic        lost_out;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state
   bit m_idle, m_lost, m_has;
   int m_pend, m_freq, m_miss;
   int m_h0, m_h1;

   pitch_frame_smoother #(
      .MIN_FREQ(16'(MINF)), .MAX_FREQ(16'(MAXF)),
      .ALPHA_SHIFT(A), .TIMEOUT_FRAMES(T)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .freq_in(freq_in),
      .freq_valid_in(freq_valid_in), .new_frame_in(new_frame_in),
      .freq_out(freq_out), .lost_out(lost_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic int clampf(int f);
      if (f < MINF) return MINF;
      if (f > MAXF) return MAXF;
      return f;
   endfunction

   // floor(d / 2^A)
   function automatic int floor_div(int d);
      int p;
      p = 1 << A;
      if (d >= 0) return d / p;
      return -((-d + p - 1) / p);
   endfunction

   function automatic int median3(int a, int b, int c);
      if ((a <= b && b <= c) || (c <= b && b <= a)) return b;
      if ((b <= a && a <= c) || (c <= a && a <= b)) return a;
      return c;
   endfunction

   task automatic model_reset();
      m_idle = 1; m_lost = 0; m_has = 0;
      m_pend = 0; m_freq = MINF; m_miss = 0;
      m_h0 = 0; m_h1 = 0;
   endtask

   task automatic model_apply(input bit v, input int f, input bit nf);
      int tgt;
      if (v) begin
         m_pend = clampf(f);
         m_has  = 1;
      end
      if (nf) begin
         if (m_has) begin
            if (m_idle || m_lost) begin
               m_freq = m_pend;
               m_h0 = m_pend; m_h1 = m_pend;
               m_idle = 0; m_lost = 0;
            end else begin
`ifdef MEDIAN3_EN
               tgt = median3(m_pend, m_h0, m_h1);
`else
               tgt = m_pend;
`endif
               m_h1 = m_h0; m_h0 = m_pend;
               m_freq = m_freq + floor_div(tgt - m_freq);
            end
            m_miss = 0;
         end else if (!m_idle) begin
            if (m_lost) begin
               m_freq = m_freq + floor_div(MINF - m_freq);
            end else begin
               m_miss++;
               if (m_miss >= T) m_lost = 1;
            end
         end
         m_has = 0;
      end
   endtask

   task automatic chk_model(input string tag);
      n_assert++;
      assert (freq_out === 16'(m_freq)) else begin
         n_fail++;
         $error("FAIL %s freq_out: got %0d expected %0d", tag, freq_out, m_freq);
      end
      n_assert++;
      assert (lost_out === m_lost) else begin
         n_fail++;
         $error("FAIL %s lost_out: got %0b expected %0b", tag, lost_out, m_lost);
      end
   endtask

   task automatic chk_const(input string tag, input int ef, input bit el);
      n_assert++;
      assert (freq_out === 16'(ef)) else begin
         n_fail++;
         $error("FAIL %s freq_out: got %0d expected %0d", tag, freq_out, ef);
      end
      n_assert++;
      assert (lost_out === el) else begin
         n_fail++;
         $error("FAIL %s lost_out: got %0b expected %0b", tag, lost_out, el);
      end
   endtask

   // One clock with the given inputs; inputs change 1 time unit after the edge
   task automatic step(input bit v, input int f, input bit nf, input string tag);
      freq_valid_in = v;
      freq_in       = 16'(f);
      new_frame_in  = nf;
      @(posedge clk_in);
      model_apply(v, f, nf);
      #1;
      freq_valid_in = 0;
      new_frame_in  = 0;
      chk_model(tag);
   endtask

   task automatic do_reset();
      rst_in = 0;
      model_reset();
      repeat (2) @(posedge clk_in);
      #1;
      chk_model("reset_hold");
      rst_in = 1;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, "gap");
   endtask

   initial begin
      rst_in = 0; freq_in = 0; freq_valid_in = 0; new_frame_in = 0;
      model_reset();
      repeat (3) @(posedge clk_in);
      #1;
      chk_const("reset", 0, 0);
      rst_in = 1;

      // first sample loads directly
      step(1, 1000, 0, "t1_cap"); gap(2);
      step(0, 0, 1, "t1_upd");
      chk_const("t1", 1000, 0);
      gap(3);

      step(1, 1400, 0, "t2_cap"); gap(2);
      step(0, 0, 1, "t2_upd");
`ifndef MEDIAN3_EN
      chk_const("t2a", 1100, 0);
`endif
      step(1, 5000, 0, "t2_cap2"); gap(1);
      step(0, 0, 1, "t2_upd2");
`ifndef MEDIAN3_EN
      chk_const("t2b", 1336, 0);
`endif

      // timeout into LOST and decay
      gap(2); step(0, 0, 1, "t3_e1");
      gap(2); step(0, 0, 1, "t3_e2");
`ifndef MEDIAN3_EN
      chk_const("t3_before", 1336, 0);
`endif
      gap(2); step(0, 0, 1, "t3_e3");
`ifndef MEDIAN3_EN
      chk_const("t3_lost", 1336, 1);
`endif
      gap(2); step(0, 0, 1, "t3_e4");
`ifndef MEDIAN3_EN
      chk_const("t3_decay", 1002, 1);
`endif

      // reset mid-frame discards pending sample
      step(1, 700, 0, "rm_cap");
      rst_in = 0;
      model_reset();
      #1;
      chk_const("rst_mid", 0, 0);
      @(posedge clk_in); #1;
      rst_in = 1;
      gap(1);
      step(0, 0, 1, "rm_next");
      chk_const("rst_next", 0, 0);

      step(1, 1000, 0, "t4_load"); step(0, 0, 1, "t4_ld");
      chk_const("t4_load", 1000, 0);
      gap(2);
      step(1, 600, 1, "t4_bypass");
`ifndef MEDIAN3_EN
      chk_const("t4", 900, 0);
`endif

      // last sample within a frame wins
      do_reset();
      step(1, 1000, 1, "t5_load"); gap(2);
      step(1, 200, 0, "t5_a"); gap(1);
      step(1, 800, 0, "t5_b"); gap(1);
      step(1, 1200, 0, "t5_c"); gap(1);
      step(0, 0, 1, "t5_upd");
`ifndef MEDIAN3_EN
      chk_const("t5", 1050, 0);
`endif

`ifdef MEDIAN3_EN
      do_reset();
      step(1, 1000, 1, "t6_load");
      step(1, 1000, 1, "t6_a"); chk_const("t6_a", 1000, 0);
      step(1, 2000, 1, "t6_b"); chk_const("t6_b", 1000, 0);
      step(1, 1000, 1, "t6_c"); chk_const("t6_c", 1000, 0);
`endif

      // random traffic: sample density varies per segment to reach LOST
      do_reset();
      for (int seg = 0; seg < 8; seg++) begin
         int pv;
         pv = (seg % 3 == 0) ? 30 : ((seg % 3 == 1) ? 3 : 0);
         for (int i = 0; i < 400; i++) begin
            bit v, nf;
            int f;
            v  = ($urandom_range(0, 99) < pv);
            nf = ($urandom_range(0, 7) == 0);
            f  = ($urandom_range(0, 9) == 0) ? int'($urandom() & 32'hFFFF)
                                             : int'($urandom_range(0, 2600));
            step(v, f, nf, "rand");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
